mem_access_ctrl: RTL and testbench

Data-memory access controller for the MIPS32 SoC memory stage. It sits directly downstream of the virtual-to-physical memory decoder. It takes the decoder's physical byte address and invalid flag, together with the pipeline's load/store request, and drives a synchronous byte-enabled data RAM. It stalls the pipeline for loads, formats sub-word loads and stores, and flags invalid or misaligned accesses without touching the RAM.

---
 rtl/mem_access_ctrl.sv | 112 +++++++++++
 tb/tb_mem_access_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MIPS32 memory-stage data access controller driving a byte-enabled synchronous RAM.
// Stores complete in one cycle; loads stall for RAM_LAT+1 cycles; bad accesses raise a one-cycle addr_err.
module mem_access_ctrl #(
    parameter int PADDR_W = 11,
    parameter int RAM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [1:0]         mem_size,
    input  logic               mem_unsigned,
    input  logic [31:0]        wdata,
    input  logic [PADDR_W-1:0] pAddr,
    input  logic               iAddr,
    output logic               stall,
    output logic [31:0]        rdata,
    output logic               addr_err,
    output logic               err_store,
    output logic               ram_en,
    output logic               ram_we,
    output logic [3:0]         ram_be,
    output logic [PADDR_W-3:0] ram_addr,
    output logic [31:0]        ram_wdata,
    input  logic [31:0]        ram_rdata
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, ERR} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        addr_err_q, addr_err_d;
    logic        err_store_q, err_store_d;
    logic [1:0]  off;
    logic        req, bad;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;

    always_comb begin
        off    = pAddr[1:0];
        req    = mem_read | mem_write;
        bad    = iAddr | (mem_size == 2'b11) | ((mem_size == 2'b01) & pAddr[0])
               | ((mem_size == 2'b10) & (off != 2'b00));
        byte_v = ram_rdata[{off, 3'b000} +: 8];
        half_v = ram_rdata[{off[1], 4'b0000} +: 16];
        load_v = mem_size == 2'b00 ? {{24{byte_v[7] & ~mem_unsigned}}, byte_v}
               : mem_size == 2'b01 ? {{16{half_v[15] & ~mem_unsigned}}, half_v}
               : ram_rdata;
        ram_be    = mem_size == 2'b00 ? 4'b0001 << off : mem_size == 2'b01 ? 4'b0011 << off : 4'b1111;
        ram_wdata = mem_size == 2'b00 ? {4{wdata[7:0]}} : mem_size == 2'b01 ? {2{wdata[15:0]}} : wdata;
        ram_addr  = pAddr[PADDR_W-1:2];
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        addr_err_d  = 1'b0;
        err_store_d = err_store_q;
        stall       = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        case (state_q)
            IDLE: if (req && !rst) begin
                if (bad) begin
                    stall       = 1'b1;
                    state_d     = ERR;
                    addr_err_d  = 1'b1;
                    err_store_d = mem_write;
                    rdata_d     = '0;
                end else if (mem_write) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                end else begin
                    ram_en  = 1'b1;
                    stall   = 1'b1;
                    cnt_d   = 2'(RAM_LAT - 1);
                    state_d = RD_WAIT;
                end
            end
            // Request inputs are held stable while stalled, so the live size/offset format the data.
            RD_WAIT: begin
                stall = 1'b1;
                if (cnt_q == 2'd0) begin
                    rdata_d = load_v;
                    state_d = RD_DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rdata_q     <= '0;
            addr_err_q  <= 1'b0;
            err_store_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            addr_err_q  <= addr_err_d;
            err_store_q <= err_store_d;
        end
    end

    assign rdata     = rdata_q;
    assign addr_err  = addr_err_q;
    assign err_store = err_store_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl at RAM_LAT=1 and RAM_LAT=3.
// A byte-array reference model predicts each response; a negedge monitor pops and compares.
module tb_mem_access_ctrl;
    localparam int PW = 11;

    typedef struct {
        int          kind;
        int          run;
        int          ens;
        logic [31:0] rdata;
        logic        es;
        logic [3:0]  be;
        logic [8:0]  addr;
        logic [31:0] wdata;
    } exp_t;

    logic clk = 0, rst = 1, sel = 0;
    logic rd = 0, wr = 0, uns = 0, ia = 0;
    logic [1:0] sz = 0;
    logic [31:0] wd = 0;
    logic [PW-1:0] pa = 0;

    logic stall_a, ae_a, es_a, en_a, we_a, stall_b, ae_b, es_b, en_b, we_b;
    logic [31:0] rdata_a, wdat_a, rdata_b, wdat_b;
    logic [3:0] be_a, be_b;
    logic [8:0] addr_a, addr_b;
    logic stall, ae, es, ram_en, ram_we;
    logic [31:0] rdata, ram_wdata;
    logic [3:0] ram_be;
    logic [8:0] ram_addr;

    logic [31:0] ram [512] = '{default: '0};
    logic [31:0] pipe [3] = '{default: '0};
    logic [7:0] ref_mem [2048] = '{default: '0};

    exp_t q[$];
    exp_t mon_e;
    int checks = 0, passes = 0, run = 0, ens = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.PADDR_W(PW), .RAM_LAT(1)) u_a (
        .clk(clk), .rst(rst), .mem_read(rd & ~sel), .mem_write(wr & ~sel), .mem_size(sz),
        .mem_unsigned(uns), .wdata(wd), .pAddr(pa), .iAddr(ia), .stall(stall_a), .rdata(rdata_a),
        .addr_err(ae_a), .err_store(es_a), .ram_en(en_a), .ram_we(we_a), .ram_be(be_a),
        .ram_addr(addr_a), .ram_wdata(wdat_a), .ram_rdata(pipe[0]));

    mem_access_ctrl #(.PADDR_W(PW), .RAM_LAT(3)) u_b (
        .clk(clk), .rst(rst), .mem_read(rd & sel), .mem_write(wr & sel), .mem_size(sz),
        .mem_unsigned(uns), .wdata(wd), .pAddr(pa), .iAddr(ia), .stall(stall_b), .rdata(rdata_b),
        .addr_err(ae_b), .err_store(es_b), .ram_en(en_b), .ram_we(we_b), .ram_be(be_b),
        .ram_addr(addr_b), .ram_wdata(wdat_b), .ram_rdata(pipe[2]));

    assign stall     = sel ? stall_b : stall_a;
    assign ae        = sel ? ae_b : ae_a;
    assign es        = sel ? es_b : es_a;
    assign ram_en    = sel ? en_b : en_a;
    assign ram_we    = sel ? we_b : we_a;
    assign rdata     = sel ? rdata_b : rdata_a;
    assign ram_wdata = sel ? wdat_b : wdat_a;
    assign ram_be    = sel ? be_b : be_a;
    assign ram_addr  = sel ? addr_b : addr_a;

    // Shared RAM; reads not requested return a poison word so mistimed captures show up.
    always @(posedge clk) begin
        if (ram_en && ram_we)
            for (int i = 0; i < 4; i++)
                if (ram_be[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        pipe[0] <= (ram_en && !ram_we) ? ram[ram_addr] : 32'hBAD0BAD0;
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            run = 0;
            ens = 0;
        end else if (stall) begin
            run++;
            if (ram_en) ens++;
        end else begin
            if (run > 0) begin
                chk("resp_queued", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    chk("resp_kind", ae ? 2 : 1, mon_e.kind);
                    chk("stall_cycles", run, mon_e.run);
                    chk("ram_en_cycles", ens, mon_e.ens);
                    chk("rdata", rdata, mon_e.rdata);
                    chk("addr_err", 32'(ae), 32'(mon_e.kind == 2));
                    if (mon_e.kind == 2) chk("err_store", 32'(es), 32'(mon_e.es));
                end
                run = 0;
                ens = 0;
            end else begin
                chk("addr_err_idle", 32'(ae), 0);
            end
            if (ram_en && ram_we) begin
                chk("store_queued", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    chk("store_kind", 0, mon_e.kind);
                    chk("ram_be", 32'(ram_be), 32'(mon_e.be));
                    chk("ram_addr", 32'(ram_addr), 32'(mon_e.addr));
                    chk("ram_wdata", ram_wdata, mon_e.wdata);
                end
            end
        end
    end

    task automatic do_req(input logic r, input logic w, input logic [1:0] s, input logic u,
                          input logic i, input logic [PW-1:0] a, input logic [31:0] d);
        exp_t e = '{default: 0};
        int n = s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
        logic [1:0] off = a[1:0];
        logic [31:0] v = 0;
        logic bad = i || s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && off != 2'd0);
        if (bad) begin
            e.kind = 2; e.run = 1; e.ens = 0; e.rdata = 0; e.es = w;
        end else if (w) begin
            e.kind  = 0;
            e.be    = n == 1 ? 4'b0001 << off : n == 2 ? 4'b0011 << off : 4'b1111;
            e.addr  = a[PW-1:2];
            e.wdata = n == 1 ? {4{d[7:0]}} : n == 2 ? {2{d[15:0]}} : d;
            for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = d[8*k +: 8];
        end else begin
            for (int k = 0; k < n; k++) v |= 32'(ref_mem[int'(a) + k]) << (8 * k);
            if (!u && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
            e.kind = 1; e.run = (sel ? 3 : 1) + 1; e.ens = 1; e.rdata = v;
        end
        q.push_back(e);
        rd = r; wr = w; sz = s; uns = u; ia = i; pa = a; wd = d;
        n = 0;
        #2;
        while (stall && n < 20) begin
            @(posedge clk); #3;
            n++;
        end
        chk("stall_bounded", 32'(n < 20), 1);
        @(posedge clk); #1;
        rd = 0; wr = 0;
    endtask

    task automatic rand_req();
        int op = $urandom_range(0, 9);
        logic [1:0] s = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
        logic [PW-1:0] a = PW'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) a = s == 2'd2 ? a & ~PW'(3) : s == 2'd1 ? a & ~PW'(1) : a;
        do_req(op >= 4, op < 4 || op == 9, s, 1'($urandom_range(0, 1)),
               $urandom_range(0, 15) == 0, a, $urandom);
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rd = 1; sz = 2; pa = 4;
        #3;
        chk("rst_stall", 32'(stall_a), 0);
        chk("rst_ram_en", 32'(en_a | en_b), 0);
        chk("rst_rdata", rdata_a | rdata_b, 0);
        chk("rst_addr_err", 32'(ae_a | ae_b), 0);
        chk("rst_err_store", 32'(es_a | es_b), 0);
        rd = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        do_req(0, 1, 2, 0, 0, 'h004, 32'hDEADBEEF);
        do_req(1, 0, 2, 0, 0, 'h004, 0);  chk("lw_word", rdata, 32'hDEADBEEF);
        do_req(1, 0, 0, 0, 0, 'h007, 0);  chk("lb", rdata, 32'hFFFFFFDE);
        do_req(1, 0, 0, 1, 0, 'h007, 0);  chk("lbu", rdata, 32'h000000DE);
        do_req(1, 0, 1, 0, 0, 'h006, 0);  chk("lh", rdata, 32'hFFFFDEAD);
        do_req(1, 0, 1, 1, 0, 'h004, 0);  chk("lhu", rdata, 32'h0000BEEF);
        do_req(0, 1, 0, 0, 0, 'h005, 32'h5A);
        do_req(1, 0, 2, 0, 0, 'h004, 0);  chk("lw_after_sb", rdata, 32'hDEAD5AEF);
        do_req(1, 0, 2, 0, 0, 'h002, 0);  chk("misaligned_rdata", rdata, 0);
        do_req(0, 1, 1, 0, 1, 'h008, 32'h1234);
        do_req(0, 1, 3, 0, 0, 'h008, 32'h1234);
        repeat (200) rand_req();
        sel = 1;
        @(posedge clk); #1;
        do_req(1, 0, 2, 0, 0, 'h004, 0);
        rd = 1; wr = 0; sz = 2; uns = 0; ia = 0; pa = 'h004;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("rst_mid_stall", 32'(stall), 0);
        chk("rst_mid_rdata", rdata, 0);
        chk("rst_mid_ram_en", 32'(ram_en), 0);
        @(posedge clk); #1;
        rd = 0; rst = 0;
        repeat (4) @(posedge clk);
        #1 chk("late_data_ignored", rdata, 0);
        do_req(1, 0, 2, 0, 0, 'h004, 0);
        repeat (100) rand_req();
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
